// File: rtl/fft_128_seq.sv
// fft_128_seq: control sequencer for an in-place radix-2 DIT FFT.
// Drives the sample RAM read and write ports and the butterfly operand,
// twiddle and stage selects. It never touches sample data.
// Phases: bit-reversed load, log2(N) butterfly stages each followed by a
// write-back drain, then a sequential unload.
module fft_128_seq #(
    parameter int N_LOG2 = 7,
    parameter int WR_LAT = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [N_LOG2-1:0] rd_addr,
    output logic              rd_sel,
    output logic              wr_en,
    output logic [N_LOG2-1:0] wr_addr,
    output logic              wr_src,
    output logic [N_LOG2-2:0] tw_idx,
    output logic [2:0]        stage,
    output logic              out_valid
);

    localparam int AW = N_LOG2;
    localparam logic [2:0]  LAST_STAGE = 3'(AW - 1);
    localparam logic [AW:0] DRAIN_LAST = (AW + 1)'(WR_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_DRAIN,
        S_UNLOAD
    } state_t;

    state_t state_q, state_d;

    // cnt_q is the phase-local counter; the extra MSB marks the end of
    // the unload read sweep.
    logic [AW:0]   cnt_q;
    logic [2:0]    stage_q;
    logic [AW-1:0] ocnt_q;

    // Write-back delay line (CALC/DRAIN) and unload read-latency line.
    logic [WR_LAT-1:0]         wb_en_q;
    logic [WR_LAT-1:0][AW-1:0] wb_addr_q;
    logic [RD_LAT-1:0]         ov_q;

    logic          load_last, calc_last, drain_last, unload_rd, last_out;
    logic          cnt_inc;
    logic [AW-2:0] k, lo_mask_n, pos_n;
    logic [AW-1:0] k_ext, lo_mask, span, addr_a, addr_b, brev;

    assign load_last  = in_valid && (cnt_q[AW-1:0] == '1);
    assign calc_last  = (cnt_q[AW-1:0] == '1);
    assign drain_last = (cnt_q == DRAIN_LAST);
    assign unload_rd  = (state_q == S_UNLOAD) && !cnt_q[AW];
    assign last_out   = (state_q == S_UNLOAD) && ov_q[RD_LAT-1] && (ocnt_q == '1);

    // Butterfly addressing: addrA is k with a zero inserted at bit 'stage',
    // addrB sets that bit; twiddle is the in-group position scaled to N/2.
    assign k         = cnt_q[AW-1:1];
    assign k_ext     = {1'b0, k};
    assign span      = AW'(1) << stage_q;
    assign lo_mask   = span - AW'(1);
    assign addr_a    = ((k_ext & ~lo_mask) << 1) | (k_ext & lo_mask);
    assign addr_b    = addr_a | span;
    assign lo_mask_n = ((AW-1)'(1) << stage_q) - (AW-1)'(1);
    assign pos_n     = k & lo_mask_n;

    // Bit-reversed load address from the accepted-sample count.
    always_comb begin
        brev = '0;
        for (int i = 0; i < AW; i++) begin
            brev[i] = cnt_q[AW-1-i];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_LOAD;
            S_LOAD:   if (load_last) state_d = S_CALC;
            S_CALC:   if (calc_last) state_d = S_DRAIN;
            S_DRAIN:  if (drain_last) state_d = (stage_q == LAST_STAGE) ? S_UNLOAD : S_CALC;
            S_UNLOAD: if (last_out) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Counter advances on every productive cycle of the current phase.
    always_comb begin
        cnt_inc = 1'b0;
        case (state_q)
            S_LOAD:          cnt_inc = in_valid;
            S_CALC, S_DRAIN: cnt_inc = 1'b1;
            S_UNLOAD:        cnt_inc = !cnt_q[AW];
            default:         cnt_inc = 1'b0;
        endcase
    end

    // Phase counter restarts on every state change; stage bumps on DRAIN->CALC.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            stage_q <= '0;
        end else begin
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == S_IDLE) begin
                stage_q <= '0;
            end else if (state_q == S_DRAIN && state_d == S_CALC) begin
                stage_q <= stage_q + 3'd1;
            end
        end
    end

    // Write-back delay: replays CALC reads WR_LAT cycles later; held empty
    // outside CALC/DRAIN so a reset or phase change leaves nothing in flight.
    always_ff @(posedge clk) begin
        if (rst || !(state_q == S_CALC || state_q == S_DRAIN)) begin
            wb_en_q   <= '0;
            wb_addr_q <= '0;
        end else begin
            wb_en_q[0]   <= (state_q == S_CALC);
            wb_addr_q[0] <= rd_addr;
            for (int i = 1; i < WR_LAT; i++) begin
                wb_en_q[i]   <= wb_en_q[i-1];
                wb_addr_q[i] <= wb_addr_q[i-1];
            end
        end
    end

    // Unload framing: out_valid trails the read strobe by the RAM latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            ov_q   <= '0;
            ocnt_q <= '0;
        end else begin
            ov_q[0] <= unload_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                ov_q[i] <= ov_q[i-1];
            end
            if (out_valid) begin
                ocnt_q <= ocnt_q + 1'b1;
            end
        end
    end

    // Output decode from state and counters.
    always_comb begin
        in_ready  = 1'b0;
        busy      = (state_q != S_IDLE);
        done      = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        rd_sel    = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_src    = 1'b0;
        tw_idx    = '0;
        stage     = '0;
        out_valid = 1'b0;
        case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                wr_en    = in_valid;
                wr_addr  = brev;
            end
            S_CALC: begin
                rd_en   = 1'b1;
                rd_sel  = cnt_q[0];
                rd_addr = cnt_q[0] ? addr_b : addr_a;
                tw_idx  = pos_n << (LAST_STAGE - stage_q);
                stage   = stage_q;
                wr_en   = wb_en_q[WR_LAT-1];
                wr_addr = wb_addr_q[WR_LAT-1];
                wr_src  = wb_en_q[WR_LAT-1];
            end
            S_DRAIN: begin
                stage   = stage_q;
                wr_en   = wb_en_q[WR_LAT-1];
                wr_addr = wb_addr_q[WR_LAT-1];
                wr_src  = wb_en_q[WR_LAT-1];
            end
            S_UNLOAD: begin
                rd_en     = unload_rd;
                rd_addr   = cnt_q[AW-1:0];
                out_valid = ov_q[RD_LAT-1];
                done      = last_out;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fft_128_seq.sv
// Scoreboard bench for fft_128_seq (N_LOG2=7, WR_LAT=4, RD_LAT=1).
// Stimulus pushes expected write, read and out_valid events with their
// cycle numbers; a negedge monitor pops and compares them as the DUT emits.
module tb_fft_128_seq;

    localparam int WL  = 4;
    localparam int BIG = 100000;

    logic       clk = 1'b0;
    logic       rst, start, in_valid;
    logic       in_ready, busy, done, rd_en, rd_sel, wr_en, wr_src, out_valid;
    logic [6:0] rd_addr, wr_addr;
    logic [5:0] tw_idx;
    logic [2:0] stage;

    fft_128_seq #(.N_LOG2(7), .WR_LAT(WL), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_sel(rd_sel),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_src(wr_src),
        .tw_idx(tw_idx), .stage(stage), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int c;
        int addr;
        int aux;
        int tw;
        int stg;
    } ev_t;

    ev_t wr_q[$], rd_q[$], ov_q[$], sp_q[$];
    bit  exp_busy[0:8191];
    bit  exp_ir[0:8191];

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    function automatic int brev7(int n);
        int r = 0;
        for (int i = 0; i < 7; i++) if (n[i]) r |= (1 << (6 - i));
        return r;
    endfunction

    function automatic ev_t mk(int c, int addr, int aux, int tw, int stg);
        ev_t e;
        e.c = c; e.addr = addr; e.aux = aux; e.tw = tw; e.stg = stg;
        return e;
    endfunction

    // Expected trace of one transform started at cycle t0; load writes every
    // 'gap' cycles; events after relative cycle 'cut' are not expected.
    task automatic push_run(int t0, int gap, int cut);
        int ld_end, b0, u, base, i, a, span;
        ld_end = 1 + gap * 127;
        b0     = ld_end + 1;
        for (int n = 0; n < 128; n++)
            if (1 + gap * n <= cut) wr_q.push_back(mk(t0 + 1 + gap * n, brev7(n), 0, -1, 0));
        for (int c = 1; c <= ld_end && c <= cut; c++) exp_ir[t0 + c] = 1'b1;
        for (int s = 0; s < 7; s++) begin
            span = 1 << s;
            base = b0 + s * (128 + WL);
            i    = 0;
            for (int g = 0; g < 64 / span; g++) begin
                for (int p = 0; p < span; p++) begin
                    a = g * 2 * span + p;
                    if (base + i <= cut)
                        rd_q.push_back(mk(t0 + base + i, a, 0, p * (64 / span), s));
                    if (base + i + 1 <= cut)
                        rd_q.push_back(mk(t0 + base + i + 1, a + span, 1, -1, s));
                    if (base + i + WL <= cut)
                        wr_q.push_back(mk(t0 + base + i + WL, a, 1, -1, 0));
                    if (base + i + 1 + WL <= cut)
                        wr_q.push_back(mk(t0 + base + i + 1 + WL, a + span, 1, -1, 0));
                    i += 2;
                end
            end
        end
        u = b0 + 7 * (128 + WL);
        for (int j = 0; j < 128; j++) begin
            if (u + j <= cut) rd_q.push_back(mk(t0 + u + j, j, 0, -1, 0));
            if (u + 1 + j <= cut) ov_q.push_back(mk(t0 + u + 1 + j, 0, (j == 127) ? 1 : 0, -1, 0));
        end
        for (int c = 1; c <= u + 128 && c <= cut; c++) exp_busy[t0 + c] = 1'b1;
    endtask

    // Directed spot value: kind 0 wr_addr, 1 rd_addr, 2 tw_idx, 3 stage, 4 wr_en, 5 done.
    task automatic spot(int c, int kind, int val);
        sp_q.push_back(mk(c, val, kind, -1, 0));
    endtask

    task automatic chk_zero(string nm);
        chk({nm, "_in_ready"}, in_ready, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_rd_en"}, rd_en, 0);
        chk({nm, "_rd_addr"}, rd_addr, 0);
        chk({nm, "_rd_sel"}, rd_sel, 0);
        chk({nm, "_wr_en"}, wr_en, 0);
        chk({nm, "_wr_addr"}, wr_addr, 0);
        chk({nm, "_wr_src"}, wr_src, 0);
        chk({nm, "_tw_idx"}, tw_idx, 0);
        chk({nm, "_stage"}, stage, 0);
        chk({nm, "_out_valid"}, out_valid, 0);
    endtask

    task automatic goto(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: per-cycle framing plus scoreboard pops for every DUT event.
    ev_t me;
    ev_t ms;
    always @(negedge clk) begin
        chk("busy", busy, exp_busy[cyc]);
        chk("in_ready", in_ready, exp_ir[cyc]);
        if (wr_en) begin
            if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
                me = wr_q.pop_front();
                chk("wr_cycle", cyc, me.c);
                chk("wr_addr", wr_addr, me.addr);
                chk("wr_src", wr_src, me.aux);
            end
        end
        if (rd_en) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
                me = rd_q.pop_front();
                chk("rd_cycle", cyc, me.c);
                chk("rd_addr", rd_addr, me.addr);
                chk("rd_sel", rd_sel, me.aux);
                chk("stage", stage, me.stg);
                if (me.tw >= 0) chk("tw_idx", tw_idx, me.tw);
            end
        end
        if (out_valid) begin
            if (ov_q.size() == 0) chk("ov_unexpected", 1, 0);
            else begin
                me = ov_q.pop_front();
                chk("ov_cycle", cyc, me.c);
                chk("done_frame", done, me.aux);
            end
        end else if (done) begin
            chk("done_stray", 1, 0);
        end
        while (sp_q.size() > 0 && sp_q[0].c <= cyc) begin
            ms = sp_q.pop_front();
            case (ms.aux)
                0: chk("spot_wr_addr", wr_addr, ms.addr);
                1: chk("spot_rd_addr", rd_addr, ms.addr);
                2: chk("spot_tw_idx", tw_idx, ms.addr);
                3: chk("spot_stage", stage, ms.addr);
                4: chk("spot_wr_en", wr_en, ms.addr);
                default: chk("spot_done", done, ms.addr);
            endcase
        end
    end

    int t0, t2, t3, t4;

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");

        // Run 1: start in the cycle reset deasserts, in_valid held high.
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b1; in_valid = 1'b1;
        t0 = cyc;
        push_run(t0, 1, BIG);
        spot(t0 + 1, 0, 0);    spot(t0 + 2, 0, 64);   spot(t0 + 3, 0, 32);
        spot(t0 + 4, 0, 96);   spot(t0 + 5, 0, 16);
        spot(t0 + 129, 1, 0);  spot(t0 + 130, 1, 1);
        spot(t0 + 131, 1, 2);  spot(t0 + 132, 1, 3);
        spot(t0 + 543, 1, 17); spot(t0 + 543, 2, 8);  spot(t0 + 543, 3, 3);
        spot(t0 + 544, 1, 25);
        spot(t0 + 1047, 1, 63); spot(t0 + 1047, 2, 63); spot(t0 + 1047, 3, 6);
        spot(t0 + 1048, 1, 127);
        spot(t0 + 1181, 5, 1);
        goto(t0 + 1); start = 1'b0;

        // Start during the done cycle is ignored; the next one is accepted.
        goto(t0 + 1181); start = 1'b1;
        goto(t0 + 1182);
        t2 = cyc;
        push_run(t2, 2, BIG);
        spot(t2 + 2, 4, 0); spot(t2 + 3, 0, 64); spot(t2 + 5, 0, 32);
        spot(t2 + 255, 0, 127);
        for (int r = 1; r <= 255; r++) begin
            goto(t2 + r);
            if (r == 1) start = 1'b0;
            in_valid = r[0];
        end
        goto(t2 + 256); in_valid = 1'b1;

        // Run 3: reset in cycle 500 (stage 2) aborts; start in cycle 501.
        goto(t2 + 1310); start = 1'b1;
        t3 = cyc;
        push_run(t3, 1, 500);
        goto(t3 + 1); start = 1'b0;
        goto(t3 + 500); rst = 1'b1;
        goto(t3 + 501); rst = 1'b0; start = 1'b1;
        @(negedge clk);
        chk_zero("abort");
        t4 = t3 + 501;
        push_run(t4, 1, BIG);
        goto(t4 + 1); start = 1'b0;

        goto(t4 + 1190);
        @(negedge clk);
        chk("wr_left", wr_q.size(), 0);
        chk("rd_left", rd_q.size(), 0);
        chk("ov_left", ov_q.size(), 0);
        chk("spot_left", sp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_128_seq.md
Name: fft_128_seq

Overview:
- Sequencer for the 128-point in-place radix-2 DIT FFT datapath. It drives the sample RAM (simple dual-port: one read port, one write port) and the butterfly unit.
- Runs four phases in order: bit-reversed load, 7 butterfly stages, pipeline drain between stages, sequential unload.
- Issues all RAM addresses, A/B operand select, twiddle index, stage number and output-valid framing. It does not touch sample data.

Parameters:
- N_LOG2, 7: log2 of FFT size; ADDR width = N_LOG2, butterflies per stage = 2^(N_LOG2-1).
- WR_LAT, 4: cycles from a read issued in CALC to the write-back of the same address. Legal range 2..15.
- RD_LAT, 1: RAM read latency in UNLOAD, in cycles. Legal range 1..3.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  begin a transform; sampled only in IDLE
- in_valid  in  1  input sample present on the datapath write bus (LOAD only)
- in_ready  out  1  high in LOAD
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse coincident with the last out_valid
- rd_en  out  1  RAM read strobe
- rd_addr  out  N_LOG2  RAM read address
- rd_sel  out  1  0 = operand A, 1 = operand B (valid with rd_en in CALC)
- wr_en  out  1  RAM write strobe
- wr_addr  out  N_LOG2  RAM write address
- wr_src  out  1  0 = external input, 1 = butterfly output
- tw_idx  out  N_LOG2-1  twiddle ROM index, valid with the A read
- stage  out  3  current stage 0..6 (0 outside CALC/DRAIN)
- out_valid  out  1  ram_out holds a result sample (UNLOAD)

Behaviour:
- Reset value of every output is 0; state is IDLE; the write-delay pipeline is cleared. rst mid-transform aborts immediately with no further writes. After rst, start is honoured the cycle it deasserts.
- States and transitions:
  - IDLE -> LOAD on start.
  - LOAD -> CALC after 128 accepted samples.
  - CALC -> DRAIN after 128 reads.
  - DRAIN -> CALC (stage+1), or -> UNLOAD if stage == 6, after exactly WR_LAT cycles.
  - UNLOAD -> IDLE after the last out_valid.
- start outside IDLE is ignored.
- LOAD:
  - in_ready = 1.
  - Each in_valid cycle: wr_en = 1, wr_src = 0, wr_addr = bitreverse(n), where n is the 7-bit sample count.
  - in_valid low stalls the count.
- CALC, stage s, butterfly k = 0..63, span = 2^s:
  - pos = k mod span.
  - addrA = ((k >> s) << (s+1)) | pos; addrB = addrA + span.
  - tw_idx = pos << (6-s).
  - Read cycles alternate: even cycle rd_addr = addrA, rd_sel = 0; odd cycle rd_addr = addrB, rd_sel = 1.
  - rd_en = 1 for 128 consecutive cycles.
- Write-back:
  - wr_en, wr_addr equal rd_en, rd_addr delayed by exactly WR_LAT cycles, with wr_src = 1.
  - The delay line runs in CALC and DRAIN only.
- DRAIN:
  - rd_en = 0; lasts WR_LAT cycles so that the final write of stage s precedes the first read of stage s+1.
  - No read-during-write to the same address across stages.
- UNLOAD:
  - rd_addr = 0..127 sequential, rd_en = 1, rd_sel = 0.
  - out_valid = rd_en delayed RD_LAT cycles.
  - done is asserted with the 128th out_valid; the state returns to IDLE the next cycle.
- Timing, with WR_LAT = 4, RD_LAT = 1, in_valid held high, start sampled at cycle 0:
  - LOAD writes: cycles 1..128.
  - Stage 0 reads: cycles 129..256; each stage takes 132 cycles.
  - UNLOAD reads: cycles 1053..1180.
  - out_valid: cycles 1054..1181; done at cycle 1181.
  - busy: cycles 1..1181.
- Simultaneous events: rst has priority over everything. A start arriving in the cycle done pulses is ignored (the state is still UNLOAD).

Test Plan:
- Reset then start, in_valid held high -> wr_addr sequence 0,64,32,96,16,… for n = 0..127; in_ready high for cycles 1..128; busy rises at cycle 1.
- Stage 0 -> reads (0,1),(2,3)…; stage 3 butterfly k = 9 -> addrA = 17, addrB = 25, tw_idx = 8; stage 6 k = 63 -> (63,127), tw_idx = 63.
- Write-back check (WR_LAT = 4) -> every wr_addr in CALC/DRAIN equals rd_addr four cycles earlier; no rd_en in DRAIN; exactly 128 writes per stage.
- Full run -> out_valid cycles 1054..1181, done only at 1181, busy falls at 1182; a second start issued at 1181 is ignored and one issued at 1182 is accepted.
- in_valid toggling 1,0,1,0 -> LOAD stretches to 255 cycles, exactly 128 writes, and bit-reversed order is preserved.
- rst asserted at cycle 500 (mid stage 2) -> all outputs 0 at cycle 501, no wr_en afterwards, busy = 0; a new start completes normally.
